gate_mac: RTL and testbench
===========================

Name: gate_mac

Overview:
- Sequential fixed-point multiply-accumulate neuron that computes one LSTM gate pre-activation: y = sum(w_k * x_k) for k = 0..N-1, plus b.
- Sits directly upstream of the tanh/sigmoid activation stages.
- o_data is in the same two's-complement Q8.16 format the activation consumes (0x010000 = 1.0).
- One weight/input pair is consumed per accepted beat; one saturated result is emitted per operation.

Parameters:
- WIDTH, 24: data width of x, w, b and the result (two's complement).
- FRAC, 16: number of fractional bits; the product is rescaled by this amount.
- N, 4: number of weight/input pairs per dot product (N >= 1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-low reset
- i_start  input  1  begin a new dot product; i_b is sampled in the same cycle
- i_b  input  WIDTH  bias, sampled on an accepted i_start
- i_valid  input  1  i_x/i_w beat valid
- i_x  input  WIDTH  input element
- i_w  input  WIDTH  weight element
- o_busy  output  1  high while accumulating or adding bias
- o_valid  output  1  one-cycle pulse: o_data holds a new result
- o_data  output  WIDTH  saturated pre-activation result

Behaviour:
- Reset (rst=0 at a clock edge) returns the block to its idle state:
  - state=IDLE; accumulator, counter and stored bias cleared.
  - o_busy=0, o_valid=0, o_data=0.
  - Reset mid-operation abandons the operation; no o_valid is produced for it.
- FSM states: IDLE, ACC, BIAS.
- IDLE:
  - i_start=1 -> ACC; acc<=0, cnt<=0, bias_r<=i_b.
  - i_valid in IDLE is ignored.
- ACC:
  - Each cycle with i_valid=1: acc <= acc + p, cnt <= cnt+1.
  - p = (i_x * i_w) as a full 2*WIDTH-bit signed product, arithmetic-shifted right by FRAC (truncation toward -inf), then sign-extended to the accumulator width.
  - Cycles with i_valid=0 hold all state (gaps are allowed).
  - The beat with cnt==N-1 and i_valid=1 -> BIAS.
- BIAS:
  - sum = acc + sign-extended bias_r.
  - Saturate: if sum > 2^(WIDTH-1)-1, o_data <= 0x7FFFFF; if sum < -2^(WIDTH-1), o_data <= 0x800000; otherwise o_data <= sum[WIDTH-1:0].
  - o_valid <= 1; next state IDLE.
- Accumulator width is 2*WIDTH signed. It never wraps for N <= 2^(WIDTH-FRAC); saturation is applied only once, at BIAS.
- o_busy = 1 in ACC and BIAS only.
- o_valid is high for exactly the one cycle following BIAS.
- o_data holds its value until the next BIAS or reset.
- i_start while busy (ACC or BIAS) is ignored; it does not restart the operation or resample i_b.
- i_start in the cycle o_valid is high (state IDLE) is accepted normally, giving back-to-back operations.
- Latency with no gaps:
  - i_start accepted at cycle 0.
  - Beats are accepted at cycles 1..N.
  - BIAS occurs at cycle N+1.
  - o_valid=1 at cycle N+2.
  - Each gap cycle adds one cycle.
- i_x, i_w and i_b are read only when accepted, as defined above; their values at other times are don't-care.

Test Plan:
- Basic sum:
  - Stimulus: N=4, i_b=0, four beats of x=0x010000, w=0x008000.
  - Required: o_valid at cycle 6, o_data=0x020000; o_busy high in cycles 1..5.
- Negative result with bias:
  - Stimulus: i_b=0x004000, four beats of x=0xFF0000, w=0x004000.
  - Required: o_data=0xFF4000 (-1.0 + 0.25 = -0.75).
- Truncation toward -inf:
  - Stimulus: four beats of x=0xFFFFFF, w=0x000001, i_b=0.
  - Required: o_data=0xFFFFFC.
  - Stimulus: four beats of x=0x000001, w=0x000001, i_b=0.
  - Required: o_data=0x000000.
- Saturation:
  - Stimulus: four beats of x=0x7F0000, w=0x7F0000.
  - Required: o_data=0x7FFFFF.
  - Stimulus: four beats of x=0x7F0000, w=0x810000.
  - Required: o_data=0x800000.
- Gaps and ignored start:
  - Stimulus: basic-sum stimulus with i_valid low for 2 cycles between beats 2 and 3; pulse i_start with i_b=0x7FFFFF during ACC.
  - Required: o_valid at cycle 8, o_data=0x020000 (bias not resampled).
  - Stimulus: i_start asserted in the o_valid cycle.
  - Required: a second operation starts and completes correctly.
- Reset mid-operation:
  - Stimulus: rst=0 after beat 2 for one cycle, then a fresh full operation with x=0x010000, w=0x010000, i_b=0.
  - Required: o_valid, o_busy and o_data read 0 after the reset, with no o_valid for the aborted operation; the fresh operation gives o_data=0x040000.

Source files
------------

// File: rtl/gate_mac_if.sv
// Handshake bundle between a gate_mac and its feeder: dot-product operands in,
// saturated Q8.16 pre-activation out.
interface gate_mac_if #(
    parameter int unsigned WIDTH = 24
);
    logic             i_start;
    logic [WIDTH-1:0] i_b;
    logic             i_valid;
    logic [WIDTH-1:0] i_x;
    logic [WIDTH-1:0] i_w;
    logic             o_busy;
    logic             o_valid;
    logic [WIDTH-1:0] o_data;

    modport master (
        output i_start, i_b, i_valid, i_x, i_w,
        input  o_busy, o_valid, o_data
    );

    modport slave (
        input  i_start, i_b, i_valid, i_x, i_w,
        output o_busy, o_valid, o_data
    );
endinterface

// File: rtl/gate_mac.sv
// Sequential fixed-point MAC for one LSTM gate: y = sum(w_k * x_k) + b,
// saturated once to WIDTH bits.
module gate_mac #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned FRAC  = 16,
    parameter int unsigned N     = 4
) (
    input logic         clk,
    input logic         rst,
    gate_mac_if.slave   bus
);
    localparam int unsigned AccW = 2 * WIDTH;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);
    localparam logic signed [AccW-1:0] SatMax = {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [AccW-1:0] SatMin = {{(WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StAcc, StBias} state_e;

    state_e                  state_q, state_d;
    logic signed [AccW-1:0]  acc_q, acc_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]        bias_q, bias_d;
    logic [WIDTH-1:0]        data_q, data_d;
    logic                    valid_q, valid_d;

    logic signed [AccW-1:0]  prod;
    logic signed [AccW-1:0]  prod_sh;
    logic signed [AccW-1:0]  sum;

    // Full-width signed product, rescaled with floor rounding.
    assign prod    = $signed(bus.i_x) * $signed(bus.i_w);
    assign prod_sh = prod >>> FRAC;
    assign sum     = acc_q + $signed({{WIDTH{bias_q[WIDTH-1]}}, bias_q});

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bias_d  = bias_q;
        data_d  = data_q;
        valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    state_d = StAcc;
                    acc_d   = '0;
                    cnt_d   = '0;
                    bias_d  = bus.i_b;
                end
            end
            StAcc: begin
                if (bus.i_valid) begin
                    acc_d = acc_q + prod_sh;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        state_d = StBias;
                    end
                end
            end
            StBias: begin
                if (sum > SatMax) begin
                    data_d = {1'b0, {(WIDTH - 1){1'b1}}};
                end else if (sum < SatMin) begin
                    data_d = {1'b1, {(WIDTH - 1){1'b0}}};
                end else begin
                    data_d = sum[WIDTH-1:0];
                end
                valid_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            bias_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bias_q  <= bias_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign bus.o_busy  = (state_q != StIdle);
    assign bus.o_valid = valid_q;
    assign bus.o_data  = data_q;
endmodule

// File: tb/tb_gate_mac.sv
// Directed bench for gate_mac: hand-computed Q8.16 results, latency, busy and
// reset behaviour.
module tb_gate_mac;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    gate_mac_if #(.WIDTH(24)) bus ();

    gate_mac #(.WIDTH(24), .FRAC(16), .N(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start asserted in the current cycle (cycle 0); result expected at cycle exp_lat.
    task automatic do_op(input string tag, input logic [23:0] b, input logic [23:0] x,
                         input logic [23:0] w, input int gap_at, input int gap_len,
                         input bit poke, input logic [23:0] exp, input int exp_lat);
        int cyc;
        bus.i_start = 1'b1;
        bus.i_b     = b;
        bus.i_valid = 1'b0;
        tick();
        cyc = 1;
        bus.i_start = 1'b0;
        bus.i_b     = 24'h5A5A5A;
        check({tag, ".nopulse"}, {31'd0, bus.o_valid}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            if (k == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    bus.i_valid = 1'b0;
                    bus.i_x     = 24'h7FFFFF;
                    bus.i_w     = 24'h7FFFFF;
                    if (poke && g == 0) begin
                        bus.i_start = 1'b1;
                        bus.i_b     = 24'h7FFFFF;
                    end
                    check({tag, ".busy_gap"}, {31'd0, bus.o_busy}, 32'd1);
                    tick();
                    cyc++;
                    bus.i_start = 1'b0;
                end
            end
            bus.i_valid = 1'b1;
            bus.i_x     = x;
            bus.i_w     = w;
            check({tag, ".busy_acc"}, {31'd0, bus.o_busy}, 32'd1);
            tick();
            cyc++;
        end
        bus.i_valid = 1'b0;
        bus.i_x     = 24'h0;
        bus.i_w     = 24'h0;
        check({tag, ".busy_bias"}, {31'd0, bus.o_busy}, 32'd1);
        while (bus.o_valid !== 1'b1 && cyc < 30) begin
            tick();
            cyc++;
        end
        check({tag, ".latency"}, cyc, exp_lat);
        check({tag, ".data"}, {8'd0, bus.o_data}, {8'd0, exp});
        check({tag, ".idle"}, {31'd0, bus.o_busy}, 32'd0);
    endtask

    task automatic idle_check(input string tag, input logic [23:0] exp);
        tick();
        check({tag, ".vlow"}, {31'd0, bus.o_valid}, 32'd0);
        check({tag, ".hold"}, {8'd0, bus.o_data}, {8'd0, exp});
    endtask

    initial begin
        bus.i_start = 1'b0;
        bus.i_b     = '0;
        bus.i_valid = 1'b0;
        bus.i_x     = '0;
        bus.i_w     = '0;
        tick();
        tick();
        check("rst.busy", {31'd0, bus.o_busy}, 32'd0);
        check("rst.valid", {31'd0, bus.o_valid}, 32'd0);
        check("rst.data", {8'd0, bus.o_data}, 32'd0);
        rst = 1'b1;
        // Beats while idle must be ignored.
        bus.i_valid = 1'b1;
        bus.i_x     = 24'h010000;
        bus.i_w     = 24'h010000;
        tick();
        check("idle.ignore", {31'd0, bus.o_busy}, 32'd0);
        bus.i_valid = 1'b0;

        do_op("basic", 24'h000000, 24'h010000, 24'h008000, -1, 0, 1'b0, 24'h020000, 6);
        idle_check("basic", 24'h020000);
        do_op("neg", 24'h004000, 24'hFF0000, 24'h004000, -1, 0, 1'b0, 24'hFF4000, 6);
        idle_check("neg", 24'hFF4000);
        do_op("trunc_n", 24'h000000, 24'hFFFFFF, 24'h000001, -1, 0, 1'b0, 24'hFFFFFC, 6);
        idle_check("trunc_n", 24'hFFFFFC);
        do_op("trunc_p", 24'h000000, 24'h000001, 24'h000001, -1, 0, 1'b0, 24'h000000, 6);
        idle_check("trunc_p", 24'h000000);
        do_op("sat_hi", 24'h000000, 24'h7F0000, 24'h7F0000, -1, 0, 1'b0, 24'h7FFFFF, 6);
        idle_check("sat_hi", 24'h7FFFFF);
        do_op("sat_lo", 24'h000000, 24'h7F0000, 24'h810000, -1, 0, 1'b0, 24'h800000, 6);
        idle_check("sat_lo", 24'h800000);
        do_op("gap", 24'h000000, 24'h010000, 24'h008000, 2, 2, 1'b1, 24'h020000, 8);
        // Back-to-back: start issued in the o_valid cycle.
        do_op("b2b", 24'h008000, 24'h010000, 24'h010000, -1, 0, 1'b0, 24'h048000, 6);
        idle_check("b2b", 24'h048000);

        // Abort after two beats.
        bus.i_start = 1'b1;
        bus.i_b     = 24'h010000;
        tick();
        bus.i_start = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_x     = 24'h010000;
        bus.i_w     = 24'h010000;
        tick();
        tick();
        bus.i_valid = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("abort.busy", {31'd0, bus.o_busy}, 32'd0);
        check("abort.valid", {31'd0, bus.o_valid}, 32'd0);
        check("abort.data", {8'd0, bus.o_data}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            idle_check("abort", 24'h000000);
        end
        do_op("fresh", 24'h000000, 24'h010000, 24'h010000, -1, 0, 1'b0, 24'h040000, 6);
        idle_check("fresh", 24'h040000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
